// File: rtl/ika9958_cpu_regwr.sv
// CPU port 1/2/3 write decoder for the VDP.
// Turns byte-pair and indirect writes into register, VRAM address and palette strobes.
module ika9958_cpu_regwr #(
   parameter int NREG = 47
) (
   input  logic        i_CLK,
   input  logic        i_RST,
   input  logic        i_WR,
   input  logic        i_RD,
   input  logic [1:0]  i_PORT,
   input  logic [7:0]  i_DIN,
   output logic        o_REG_WE,
   output logic [5:0]  o_REG_ADDR,
   output logic [7:0]  o_REG_DATA,
   output logic        o_VA_WE,
   output logic [13:0] o_VA,
   output logic        o_VA_WR,
   output logic        o_PAL_WE,
   output logic [3:0]  o_PAL_ADDR,
   output logic [8:0]  o_PAL_DATA
);

   localparam logic P_FIRST  = 1'b0;
   localparam logic P_SECOND = 1'b1;
   localparam logic [6:0] NREG_W = 7'(NREG);

   logic       p1_phase;
   logic       p2_phase;
   logic [7:0] p1_latch;
   logic [7:0] p2_latch;
   logic [7:0] r17;
   logic [3:0] pal_idx;

   logic       rw_req;
   logic       rw_ok;
   logic [5:0] rw_addr;
   logic [7:0] rw_data;

   // Both register-write sources share one strobe; only one port is active per cycle.
   always_comb begin
      rw_req  = 1'b0;
      rw_addr = 6'd0;
      rw_data = 8'd0;
      if (i_WR && i_PORT == 2'd1 && p1_phase == P_SECOND && i_DIN[7]) begin
         rw_req  = 1'b1;
         rw_addr = i_DIN[5:0];
         rw_data = p1_latch;
      end else if (i_WR && i_PORT == 2'd3 && r17[5:0] != 6'd17) begin
         rw_req  = 1'b1;
         rw_addr = r17[5:0];
         rw_data = i_DIN;
      end
   end

   assign rw_ok = rw_req && ({1'b0, rw_addr} < NREG_W);

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         o_REG_WE   <= 1'b0;
         o_REG_ADDR <= 6'd0;
         o_REG_DATA <= 8'd0;
         o_VA_WE    <= 1'b0;
         o_VA       <= 14'd0;
         o_VA_WR    <= 1'b0;
         o_PAL_WE   <= 1'b0;
         o_PAL_ADDR <= 4'd0;
         o_PAL_DATA <= 9'd0;
         p1_phase   <= P_FIRST;
         p2_phase   <= P_FIRST;
         p1_latch   <= 8'd0;
         p2_latch   <= 8'd0;
         r17        <= 8'd0;
         pal_idx    <= 4'd0;
      end else begin
         o_REG_WE <= 1'b0;
         o_VA_WE  <= 1'b0;
         o_PAL_WE <= 1'b0;

         if (rw_ok) begin
            o_REG_WE   <= 1'b1;
            o_REG_ADDR <= rw_addr;
            o_REG_DATA <= rw_data;
         end

         if (i_WR) begin
            case (i_PORT)
               2'd1: begin
                  if (p1_phase == P_FIRST) begin
                     p1_latch <= i_DIN;
                     p1_phase <= P_SECOND;
                  end else begin
                     p1_phase <= P_FIRST;
                     if (!i_DIN[7]) begin
                        o_VA_WE <= 1'b1;
                        o_VA    <= {i_DIN[5:0], p1_latch};
                        o_VA_WR <= i_DIN[6];
                     end
                  end
               end
               2'd2: begin
                  if (p2_phase == P_FIRST) begin
                     p2_latch <= i_DIN;
                     p2_phase <= P_SECOND;
                  end else begin
                     p2_phase   <= P_FIRST;
                     o_PAL_WE   <= 1'b1;
                     o_PAL_ADDR <= pal_idx;
                     o_PAL_DATA <= {p2_latch[6:4], i_DIN[2:0], p2_latch[2:0]};
                     pal_idx    <= pal_idx + 4'd1;
                  end
               end
               2'd3: begin
                  if (!r17[7])
                     r17[5:0] <= r17[5:0] + 6'd1;
               end
               default: ;
            endcase
         end else if (i_RD && i_PORT == 2'd1) begin
            p1_phase <= P_FIRST;
         end

         // Register side effects come last so they win over the port logic above.
         if (rw_ok && rw_addr == 6'd17)
            r17 <= rw_data;
         if (rw_ok && rw_addr == 6'd16) begin
            pal_idx  <= rw_data[3:0];
            p2_phase <= P_FIRST;
         end
      end
   end

endmodule

// File: tb/tb_ika9958_cpu_regwr.sv
// Directed bench for ika9958_cpu_regwr.
// Pulses are counted 1 ns after each rising edge; inputs change on falling edges.
module tb_ika9958_cpu_regwr;

   logic        i_CLK = 1'b0;
   logic        i_RST = 1'b1;
   logic        i_WR = 1'b0;
   logic        i_RD = 1'b0;
   logic [1:0]  i_PORT = 2'd0;
   logic [7:0]  i_DIN = 8'd0;
   logic        o_REG_WE;
   logic [5:0]  o_REG_ADDR;
   logic [7:0]  o_REG_DATA;
   logic        o_VA_WE;
   logic [13:0] o_VA;
   logic        o_VA_WR;
   logic        o_PAL_WE;
   logic [3:0]  o_PAL_ADDR;
   logic [8:0]  o_PAL_DATA;

   int errors = 0;
   int checks = 0;
   int reg_cnt = 0;
   int va_cnt = 0;
   int pal_cnt = 0;

   ika9958_cpu_regwr dut (
      .i_CLK(i_CLK), .i_RST(i_RST), .i_WR(i_WR), .i_RD(i_RD),
      .i_PORT(i_PORT), .i_DIN(i_DIN),
      .o_REG_WE(o_REG_WE), .o_REG_ADDR(o_REG_ADDR), .o_REG_DATA(o_REG_DATA),
      .o_VA_WE(o_VA_WE), .o_VA(o_VA), .o_VA_WR(o_VA_WR),
      .o_PAL_WE(o_PAL_WE), .o_PAL_ADDR(o_PAL_ADDR), .o_PAL_DATA(o_PAL_DATA)
   );

   always #5 i_CLK = ~i_CLK;

   always @(posedge i_CLK) begin
      #1;
      if (o_REG_WE === 1'b1) reg_cnt++;
      if (o_VA_WE === 1'b1) va_cnt++;
      if (o_PAL_WE === 1'b1) pal_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [1:0] p, input logic [7:0] d);
      @(negedge i_CLK);
      i_PORT = p;
      i_DIN = d;
      i_WR = 1'b1;
      i_RD = 1'b0;
      @(negedge i_CLK);
      i_WR = 1'b0;
   endtask

   task automatic rd(input logic [1:0] p);
      @(negedge i_CLK);
      i_PORT = p;
      i_RD = 1'b1;
      @(negedge i_CLK);
      i_RD = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge i_CLK);
      i_RST = 1'b1;
      @(negedge i_CLK);
      i_RST = 1'b0;
   endtask

   task automatic chk_reg(input string tag, input int cnt, input logic [5:0] a,
                          input logic [7:0] d);
      check({tag, "_cnt"}, 64'(reg_cnt), 64'(cnt));
      check({tag, "_addr"}, 64'(o_REG_ADDR), 64'(a));
      check({tag, "_data"}, 64'(o_REG_DATA), 64'(d));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge i_CLK);
      i_RST = 1'b0;
      check("reset_outputs",
            64'({o_REG_WE, o_REG_ADDR, o_REG_DATA, o_VA_WE, o_VA, o_VA_WR,
                 o_PAL_WE, o_PAL_ADDR, o_PAL_DATA}), 64'd0);

      wr(1, 8'h1F);
      check("p1_first_no_pulse", 64'(reg_cnt), 64'd0);
      wr(1, 8'h87);
      chk_reg("r7", 1, 6'd7, 8'h1F);
      wr(1, 8'h1F);
      wr(1, 8'hC7);
      chk_reg("r7_bit6", 2, 6'd7, 8'h1F);

      wr(1, 8'h34);
      wr(1, 8'h52);
      check("va_cnt1", 64'(va_cnt), 64'd1);
      check("va_1234", 64'(o_VA), 64'h1234);
      check("va_wr1", 64'(o_VA_WR), 64'd1);
      check("va_no_reg", 64'(reg_cnt), 64'd2);
      wr(1, 8'h00);
      wr(1, 8'h3F);
      check("va_cnt2", 64'(va_cnt), 64'd2);
      check("va_3f00", 64'(o_VA), 64'h3F00);
      check("va_wr0", 64'(o_VA_WR), 64'd0);

      wr(1, 8'h55);
      rd(1);
      wr(1, 8'h66);
      wr(1, 8'h88);
      chk_reg("status_rd", 3, 6'd8, 8'h66);

      wr(1, 8'h55);
      do_reset();
      check("mid_reset_outputs",
            64'({o_REG_WE, o_REG_ADDR, o_REG_DATA, o_VA_WE, o_VA, o_VA_WR,
                 o_PAL_WE, o_PAL_ADDR, o_PAL_DATA}), 64'd0);
      check("mid_reset_no_pulse", 64'(reg_cnt + va_cnt), 64'd5);
      wr(1, 8'h66);
      wr(1, 8'h88);
      chk_reg("after_reset", 4, 6'd8, 8'h66);

      wr(1, 8'h02);
      wr(1, 8'h91);
      chk_reg("r17_02", 5, 6'd17, 8'h02);
      wr(3, 8'hAA);
      chk_reg("p3_r2", 6, 6'd2, 8'hAA);
      wr(3, 8'hBB);
      chk_reg("p3_r3", 7, 6'd3, 8'hBB);
      wr(3, 8'hCC);
      chk_reg("p3_r4", 8, 6'd4, 8'hCC);

      wr(1, 8'h85);
      wr(1, 8'h91);
      wr(3, 8'h11);
      chk_reg("aii_a", 10, 6'd5, 8'h11);
      wr(3, 8'h22);
      chk_reg("aii_b", 11, 6'd5, 8'h22);

      wr(1, 8'h10);
      wr(1, 8'h91);
      wr(3, 8'h01);
      chk_reg("p3_r16", 13, 6'd16, 8'h01);
      wr(3, 8'h02);
      check("p3_r17_skip", 64'(reg_cnt), 64'd13);
      wr(3, 8'h03);
      chk_reg("p3_r18", 14, 6'd18, 8'h03);

      wr(1, 8'h3F);
      wr(1, 8'h91);
      wr(3, 8'h44);
      check("p3_r63_skip", 64'(reg_cnt), 64'd15);
      wr(3, 8'h55);
      chk_reg("p3_wrap", 16, 6'd0, 8'h55);

      wr(1, 8'h0F);
      wr(1, 8'h90);
      wr(2, 8'h73);
      check("pal_first_no_pulse", 64'(pal_cnt), 64'd0);
      wr(2, 8'h05);
      check("pal_cnt1", 64'(pal_cnt), 64'd1);
      check("pal_addr15", 64'(o_PAL_ADDR), 64'd15);
      check("pal_data15", 64'(o_PAL_DATA), 64'(9'b111_101_011));
      wr(2, 8'h00);
      wr(2, 8'h07);
      check("pal_wrap_addr", 64'(o_PAL_ADDR), 64'd0);
      check("pal_wrap_data", 64'(o_PAL_DATA), 64'(9'b000_111_000));

      wr(2, 8'h11);
      wr(1, 8'h04);
      wr(1, 8'h90);
      wr(2, 8'h22);
      check("pal_r16_nopulse", 64'(pal_cnt), 64'd2);
      wr(2, 8'h07);
      check("pal_r16_cnt", 64'(pal_cnt), 64'd3);
      check("pal_r16_addr", 64'(o_PAL_ADDR), 64'd4);
      check("pal_r16_data", 64'(o_PAL_DATA), 64'(9'b010_111_010));

      wr(1, 8'h00);
      wr(1, 8'hB2);
      chk_reg("r50_skip", 18, 6'd16, 8'h04);
      wr(1, 8'h5A);
      wr(1, 8'h81);
      chk_reg("after_r50", 19, 6'd1, 8'h5A);

      wr(0, 8'hFF);
      check("port0_none", 64'(reg_cnt + va_cnt + pal_cnt), 64'd24);

      wr(1, 8'hAB);
      wr(2, 8'h33);
      wr(1, 8'h82);
      chk_reg("mix_reg", 20, 6'd2, 8'hAB);
      wr(2, 8'h06);
      check("mix_pal_addr", 64'(o_PAL_ADDR), 64'd5);
      check("mix_pal_data", 64'(o_PAL_DATA), 64'(9'b011_110_011));
      check("mix_pal_cnt", 64'(pal_cnt), 64'd4);

      repeat (2) @(negedge i_CLK);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
